// File: rtl/cpu_ctrl_pkg.sv
// Shared constants, state encoding and opcode helpers for the instruction-side control unit.
package cpu_ctrl_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefNreg  = 8;
    localparam int unsigned DefRselW = 3;

    // Instruction field positions: op [15:12], rx [11:9], ry [8:6], imm8 [7:0]
    localparam int unsigned OpLo  = 12;
    localparam int unsigned RxLo  = 9;
    localparam int unsigned RyLo  = 6;
    localparam int unsigned ImmLo = 0;

    localparam logic [3:0] OpMv   = 4'h0;
    localparam logic [3:0] OpMvi  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpOr   = 4'h5;
    localparam logic [3:0] OpXor  = 4'h6;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluAnd = 3'd2;
    localparam logic [2:0] AluOr  = 3'd3;
    localparam logic [2:0] AluXor = 3'd4;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StEx1, StEx2, StEx3, StHalt
    } state_e;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OpAdd) && (op <= OpXor);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op > OpXor) && (op != OpHalt);
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            OpSub:   return AluSub;
            OpAnd:   return AluAnd;
            OpOr:    return AluOr;
            OpXor:   return AluXor;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Register-select to one-hot strobe decoder; all zeros when not enabled.
module onehot_dec #(
    parameter int unsigned RSEL_W = 3,
    parameter int unsigned NREG   = 8
) (
    input  logic              en,
    input  logic [RSEL_W-1:0] sel,
    output logic [NREG-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            onehot[i] = en && (sel == RSEL_W'(i));
        end
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit CPU. Strobes are registered from the next state;
// only ir_write/pc_inc and the DECODE-cycle illegal/done depend combinationally on inputs.
module ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned NREG   = DefNreg,
    parameter int unsigned RSEL_W = DefRselW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] ir_data,
    output logic              mem_rd,
    output logic              ir_write,
    output logic              ir_read,
    output logic              pc_inc,
    output logic [NREG-1:0]   reg_in,
    output logic [NREG-1:0]   reg_out,
    output logic              imm_out,
    output logic [DATA_W-1:0] imm_value,
    output logic              a_load,
    output logic              g_load,
    output logic              g_out,
    output logic [2:0]        alu_op,
    output logic              done,
    output logic              illegal,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [RSEL_W-1:0] rx_q, rx_d, ry_q, ry_d;
    logic [7:0]        imm_q, imm_d;
    logic [3:0]        dec_op;
    logic              dec_illegal;

    logic              mem_rd_q, ir_read_q, imm_out_q, a_load_q, g_load_q, g_out_q;
    logic              done_q, halted_q, reg_in_en_q, reg_out_en_q;
    logic [RSEL_W-1:0] reg_in_sel_q, reg_out_sel_q;
    logic [2:0]        alu_op_q;
    logic              mem_rd_d, ir_read_d, imm_out_d, a_load_d, g_load_d, g_out_d;
    logic              done_d, halted_d, reg_in_en_d, reg_out_en_d;
    logic [RSEL_W-1:0] reg_in_sel_d, reg_out_sel_d;
    logic [2:0]        alu_op_d;

    assign dec_op = ir_data[OpLo +: 4];

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rx_d          = rx_q;
        ry_d          = ry_q;
        imm_d         = imm_q;
        dec_illegal   = 1'b0;
        mem_rd_d      = 1'b0;
        ir_read_d     = 1'b0;
        imm_out_d     = 1'b0;
        a_load_d      = 1'b0;
        g_load_d      = 1'b0;
        g_out_d       = 1'b0;
        done_d        = 1'b0;
        halted_d      = 1'b0;
        reg_in_en_d   = 1'b0;
        reg_out_en_d  = 1'b0;
        reg_in_sel_d  = '0;
        reg_out_sel_d = '0;
        alu_op_d      = '0;

        unique case (state_q)
            StIdle:   if (run) state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                op_d  = dec_op;
                rx_d  = ir_data[RxLo +: RSEL_W];
                ry_d  = ir_data[RyLo +: RSEL_W];
                imm_d = ir_data[ImmLo +: 8];
                if (dec_op == OpHalt) begin
                    state_d = StHalt;
                end else if (is_illegal(dec_op)) begin
                    dec_illegal = 1'b1;
                    state_d     = run ? StFetch : StIdle;
                end else begin
                    state_d = StEx1;
                end
            end
            StEx1:    state_d = is_alu(op_q) ? StEx2 : (run ? StFetch : StIdle);
            StEx2:    state_d = StEx3;
            StEx3:    state_d = run ? StFetch : StIdle;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase

        // Strobes for the cycle we are about to enter, so they come straight off flops
        case (state_d)
            StFetch:  mem_rd_d  = 1'b1;
            StDecode: ir_read_d = 1'b1;
            StEx1: begin
                reg_in_sel_d = rx_d;
                if (op_d == OpMv) begin
                    reg_out_en_d  = 1'b1;
                    reg_out_sel_d = ry_d;
                    reg_in_en_d   = 1'b1;
                    done_d        = 1'b1;
                end else if (op_d == OpMvi) begin
                    imm_out_d   = 1'b1;
                    reg_in_en_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    reg_out_en_d  = 1'b1;
                    reg_out_sel_d = rx_d;
                    a_load_d      = 1'b1;
                end
            end
            StEx2: begin
                reg_out_en_d  = 1'b1;
                reg_out_sel_d = ry_d;
                alu_op_d      = alu_code(op_d);
                g_load_d      = 1'b1;
            end
            StEx3: begin
                g_out_d      = 1'b1;
                reg_in_en_d  = 1'b1;
                reg_in_sel_d = rx_d;
                done_d       = 1'b1;
            end
            StHalt:   halted_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            op_q          <= '0;
            rx_q          <= '0;
            ry_q          <= '0;
            imm_q         <= '0;
            mem_rd_q      <= 1'b0;
            ir_read_q     <= 1'b0;
            imm_out_q     <= 1'b0;
            a_load_q      <= 1'b0;
            g_load_q      <= 1'b0;
            g_out_q       <= 1'b0;
            done_q        <= 1'b0;
            halted_q      <= 1'b0;
            reg_in_en_q   <= 1'b0;
            reg_out_en_q  <= 1'b0;
            reg_in_sel_q  <= '0;
            reg_out_sel_q <= '0;
            alu_op_q      <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rx_q          <= rx_d;
            ry_q          <= ry_d;
            imm_q         <= imm_d;
            mem_rd_q      <= mem_rd_d;
            ir_read_q     <= ir_read_d;
            imm_out_q     <= imm_out_d;
            a_load_q      <= a_load_d;
            g_load_q      <= g_load_d;
            g_out_q       <= g_out_d;
            done_q        <= done_d;
            halted_q      <= halted_d;
            reg_in_en_q   <= reg_in_en_d;
            reg_out_en_q  <= reg_out_en_d;
            reg_in_sel_q  <= reg_in_sel_d;
            reg_out_sel_q <= reg_out_sel_d;
            alu_op_q      <= alu_op_d;
        end
    end

    onehot_dec #(.RSEL_W(RSEL_W), .NREG(NREG)) u_reg_in_dec (
        .en     (reg_in_en_q),
        .sel    (reg_in_sel_q),
        .onehot (reg_in)
    );

    onehot_dec #(.RSEL_W(RSEL_W), .NREG(NREG)) u_reg_out_dec (
        .en     (reg_out_en_q),
        .sel    (reg_out_sel_q),
        .onehot (reg_out)
    );

    assign mem_rd    = mem_rd_q;
    assign ir_write  = (state_q == StFetch) && mem_ready;
    assign pc_inc    = (state_q == StFetch) && mem_ready;
    assign ir_read   = ir_read_q;
    assign imm_out   = imm_out_q;
    assign imm_value = {{(DATA_W-8){1'b0}}, imm_q};
    assign a_load    = a_load_q;
    assign g_load    = g_load_q;
    assign g_out     = g_out_q;
    assign alu_op    = alu_op_q;
    assign done      = done_q | dec_illegal;
    assign illegal   = dec_illegal;
    assign halted    = halted_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: per-cycle output snapshots against hand-built expectations,
// plus bus-driver and reg_in one-hot invariants on every falling edge.
module tb_ctrl_fsm;

    logic        clk;
    logic        reset;
    logic        run;
    logic        mem_ready;
    logic [15:0] ir_data;
    logic        mem_rd, ir_write, ir_read, pc_inc;
    logic [7:0]  reg_in, reg_out;
    logic        imm_out;
    logic [15:0] imm_value;
    logic        a_load, g_load, g_out;
    logic [2:0]  alu_op;
    logic        done, illegal, halted;
    logic [29:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    // Snapshot layout: mem_rd ir_write ir_read pc_inc reg_in reg_out imm_out a_load g_load g_out
    // alu_op done illegal halted
    localparam logic [29:0] MRD  = 30'h2000_0000;
    localparam logic [29:0] IRW  = 30'h1000_0000;
    localparam logic [29:0] IRD  = 30'h0800_0000;
    localparam logic [29:0] PCI  = 30'h0400_0000;
    localparam logic [29:0] IMM  = 30'h0000_0200;
    localparam logic [29:0] ALD  = 30'h0000_0100;
    localparam logic [29:0] GLD  = 30'h0000_0080;
    localparam logic [29:0] GOUT = 30'h0000_0040;
    localparam logic [29:0] DN   = 30'h0000_0004;
    localparam logic [29:0] ILL  = 30'h0000_0002;
    localparam logic [29:0] HLT  = 30'h0000_0001;
    localparam logic [29:0] FTC  = MRD | IRW | PCI;

    function automatic logic [29:0] ri(input logic [7:0] v);
        return 30'(v) << 18;
    endfunction
    function automatic logic [29:0] ro(input logic [7:0] v);
        return 30'(v) << 10;
    endfunction
    function automatic logic [29:0] aop(input logic [2:0] v);
        return 30'(v) << 3;
    endfunction

    assign obs = {mem_rd, ir_write, ir_read, pc_inc, reg_in, reg_out, imm_out, a_load, g_load,
                  g_out, alu_op, done, illegal, halted};

    ctrl_fsm u_dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_ready (mem_ready),
        .ir_data   (ir_data),
        .mem_rd    (mem_rd),
        .ir_write  (ir_write),
        .ir_read   (ir_read),
        .pc_inc    (pc_inc),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .imm_out   (imm_out),
        .imm_value (imm_value),
        .a_load    (a_load),
        .g_load    (g_load),
        .g_out     (g_out),
        .alu_op    (alu_op),
        .done      (done),
        .illegal   (illegal),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("bus_excl", 32'(($countones(reg_out) + 32'(imm_out) + 32'(g_out)) <= 1), 32'd1);
        check("mem_rd_excl", 32'(mem_rd && ((reg_out != 8'h00) || imm_out || g_out)), 32'd0);
        check("reg_in_1hot", 32'($countones(reg_in) <= 1), 32'd1);
    end

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        ir_data   = 16'h0000;
        #3 reset = 1'b0;
        tick();
        tick();
        check("reset_obs", 32'(obs), 32'd0);
        check("reset_imm", 32'(imm_value), 32'd0);
        @(negedge clk) reset = 1'b1;

        // MVI R5,0x55
        run = 1'b1; mem_ready = 1'b1; ir_data = 16'h1A55;
        tick(); check("mvi_fetch", 32'(obs), 32'(FTC));
        tick(); check("mvi_decode", 32'(obs), 32'(IRD));
        tick(); check("mvi_ex1", 32'(obs), 32'(IMM | ri(8'h20) | DN));
        check("mvi_imm", 32'(imm_value), 32'h0055);

        // ADD R1,R2
        ir_data = 16'h2280;
        tick(); check("add_fetch", 32'(obs), 32'(FTC));
        tick(); check("add_decode", 32'(obs), 32'(IRD));
        tick(); check("add_ex1", 32'(obs), 32'(ro(8'h02) | ALD));
        tick(); check("add_ex2", 32'(obs), 32'(ro(8'h04) | GLD | aop(3'd0)));
        tick(); check("add_ex3", 32'(obs), 32'(GOUT | ri(8'h02) | DN));

        // MV R3,R3 with a stalled fetch
        ir_data = 16'h06C0; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); check("stall_fetch", 32'(obs), 32'(MRD));
        end
        mem_ready = 1'b1;
        #1 check("stall_ready", 32'(obs), 32'(FTC));
        tick(); check("mv_decode", 32'(obs), 32'(IRD));
        tick(); check("mv_ex1", 32'(obs), 32'(ro(8'h08) | ri(8'h08) | DN));

        // Illegal opcode 9
        ir_data = 16'h9000;
        tick(); check("ill_fetch", 32'(obs), 32'(FTC));
        tick(); check("ill_decode", 32'(obs), 32'(IRD | ILL | DN));
        tick(); check("ill_refetch", 32'(obs), 32'(FTC));

        // HALT
        ir_data = 16'hF000;
        tick(); check("halt_decode", 32'(obs), 32'(IRD));
        tick(); check("halt_enter", 32'(obs), 32'(HLT));
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            tick(); check("halt_hold", 32'(obs), 32'(HLT));
        end
        #2 reset = 1'b0;
        #1 check("halt_reset", 32'(obs), 32'd0);
        @(negedge clk) reset = 1'b1;

        // SUB R4,R5 aborted by reset in EX2
        run = 1'b1; mem_ready = 1'b1; ir_data = 16'h3940;
        tick(); check("sub_fetch", 32'(obs), 32'(FTC));
        tick(); check("sub_decode", 32'(obs), 32'(IRD));
        tick(); check("sub_ex1", 32'(obs), 32'(ro(8'h10) | ALD));
        tick(); check("sub_ex2", 32'(obs), 32'(ro(8'h20) | GLD | aop(3'd1)));
        #2 reset = 1'b0;
        #1 check("sub_async_rst", 32'(obs), 32'd0);
        check("sub_rst_imm", 32'(imm_value), 32'd0);
        tick(); check("sub_rst_hold", 32'(obs), 32'd0);
        ir_data = 16'h0E40;
        @(negedge clk) reset = 1'b1;

        // Fresh MV R7,R1 after the abort, then go idle
        tick(); check("re_fetch", 32'(obs), 32'(FTC));
        tick(); check("re_decode", 32'(obs), 32'(IRD));
        run = 1'b0;
        tick(); check("re_ex1", 32'(obs), 32'(ro(8'h02) | ri(8'h80) | DN));
        tick(); check("idle_obs", 32'(obs), 32'd0);
        tick(); check("idle_hold", 32'(obs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
